bin2qdi_e1of3_tx: RTL and testbench
===================================

BIN2QDI_E1OF3_TX -- requirements
Module: bin2qdi_e1of3_tx

Interface
REQ-001 Parameter DEPTH, default 4: number of entries in the input FIFO (power of two, 2..16).
REQ-002 Parameter SYNC_STAGES, default 2: number of flip-flop stages synchronising Re into the CLK domain.
REQ-003 CLK  input  1  binary-side clock; all state changes on the rising edge.
REQ-004 RESET  input  1  reset, asynchronous, active-low.
REQ-005 din  input  2  binary symbol from the Verilog side: 00, 01 or 10.
REQ-006 din_valid  input  1  din holds a symbol this cycle.
REQ-007 din_ready  output  1  FIFO can accept a symbol this cycle.
REQ-008 err  output  1  one-cycle pulse when an invalid symbol (11) is offered.
REQ-009 R  output  3  e1of3 DI data to the QDI circuit, one-hot or neutral (000).
REQ-010 Re  input  1  right enable from the QDI circuit; high = ready for data, low = data acknowledged.
REQ-011 tok_cnt  output  8  count of completed four-phase tokens, modulo 256.
REQ-012 busy  output  1  high when the FIFO is non-empty or the state is not IDLE.
REQ-013 VDD, GND  inout  1  supply pins, no logical function.

Function
REQ-014 The block SHALL accept a symbol on any rising CLK edge where din_valid=1, din_ready=1 and din != 11.
REQ-015 din_ready SHALL be 1 exactly when the FIFO is not full; enqueue while full SHALL NOT occur, even if a dequeue happens in the same cycle.
REQ-016 din=11 with din_valid=1 SHALL NOT be enqueued; err SHALL be 1 for the following cycle only; din_ready is unaffected.
REQ-017 Re SHALL be synchronised through SYNC_STAGES flops to re_s; only re_s is used by the state machine.
REQ-018 The FSM SHALL have three states: IDLE, SEND and NEUTRAL.
REQ-019 IDLE: R=000; if the FIFO is non-empty and re_s=1, pop the head, drive R=onehot(head), and go to SEND.
REQ-020 Onehot mapping SHALL be 00->001, 01->010, 10->100.
REQ-021 SEND: R holds its value; on re_s=0, R becomes 000, tok_cnt increments (wraps 255->0), and the FSM goes to NEUTRAL.
REQ-022 NEUTRAL: R=000; on re_s=1, go to IDLE. The next pop happens no earlier than the following edge.
REQ-023 R SHALL be driven from registers only, never change between two non-neutral codes, and never have more than one bit high.
REQ-024 Latency: a symbol accepted at edge k into an empty FIFO, with re_s=1 and the FSM in IDLE, SHALL appear on R after edge k+2.
REQ-025 Symbols SHALL be emitted in acceptance order with no loss or duplication; FIFO pointers wrap modulo DEPTH.
REQ-026 A simultaneous enqueue and pop on a non-full FIFO SHALL both take effect, leaving the occupancy unchanged.
REQ-027 If re_s is 0 in IDLE, the FSM SHALL wait in IDLE with R=000; no token is issued until the receiver re-enables.

Reset
REQ-028 While RESET=0: R=000, din_ready=0, err=0, tok_cnt=0, busy=0, FSM=IDLE, FIFO empty, synchroniser flops cleared to 0.
REQ-029 RESET assertion mid-token SHALL force R=000 immediately (asynchronously) and discard all queued symbols.
REQ-030 After RESET rises, din_ready SHALL be 1 from the first rising CLK edge; no token is issued until re_s=1.

Verification
REQ-031 Reset release, Re held 1, single write din=01 -> R=010 two edges after acceptance; drop Re -> R=000, tok_cnt=1; raise Re -> back to IDLE.
REQ-032 Burst of 00,01,10,00 with a bench receiver doing a four-phase handshake with 3-cycle Re delay -> R sequence 001,010,100,001, each separated by 000; tok_cnt=4.
REQ-033 Re held 0 while writing DEPTH+1 symbols -> din_ready falls after 4 accepts, 5th not taken, R stays 000; release Re -> 4 tokens sent in order.
REQ-034 din=11 with din_valid=1 -> err pulses for one cycle, FIFO occupancy unchanged, no token issued.
REQ-035 Assert RESET while in SEND with R=100 and 2 entries queued -> R=000 at once; after release no stale token appears; busy=0.
REQ-036 Send 257 tokens -> tok_cnt reads 1; a checker confirms R is never multi-hot and never changes directly between two non-neutral codes.

Source files
------------

// File: rtl/bin2qdi_e1of3_tx_if.sv
// Handshake bundle between the binary-side writer and the e1of3 DI transmitter.
// master = symbol writer / QDI receiver side, slave = the transmitter.
interface bin2qdi_e1of3_tx_if;
  logic [1:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       err;
  logic [2:0] R;
  logic       Re;
  logic [7:0] tok_cnt;
  logic       busy;

  modport master (
    output din, din_valid, Re,
    input  din_ready, err, R, tok_cnt, busy
  );

  modport slave (
    input  din, din_valid, Re,
    output din_ready, err, R, tok_cnt, busy
  );
endinterface

// File: rtl/bin2qdi_e1of3_tx.sv
// Binary-to-QDI bridge: FIFO of 2-bit symbols emitted as four-phase e1of3 tokens on R.
//   state     | meaning
//   S_IDLE    | R neutral, waiting for a queued symbol and re_s=1
//   S_SEND    | R holds one-hot code, waiting for re_s=0 (acknowledge)
//   S_NEUTRAL | R neutral, waiting for re_s=1 before the next token
module bin2qdi_e1of3_tx #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  inout  wire  VDD,
  inout  wire  GND,
  bin2qdi_e1of3_tx_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEND    = 2'd1,
    S_NEUTRAL = 2'd2
  } state_t;

  state_t                 r_state, w_state_next;
  logic [SYNC_STAGES-1:0] r_re_sync;
  logic [1:0]             r_mem [DEPTH];
  logic [AW-1:0]          r_wptr, r_rptr;
  logic [AW:0]            r_count;
  logic                   r_nempty_d;
  logic                   r_alive;
  logic                   r_err;
  logic [2:0]             r_R, w_r_next, w_head_oh;
  logic [7:0]             r_tok_cnt;
  logic                   w_re_s, w_full, w_nempty, w_din_ready;
  logic                   w_push, w_pop, w_tok_inc;

  assign w_re_s      = r_re_sync[SYNC_STAGES-1];
  assign w_full      = (r_count == (AW+1)'(DEPTH));
  assign w_nempty    = (r_count != '0);
  assign w_din_ready = r_alive && !w_full;
  assign w_push      = bus.din_valid && w_din_ready && (bus.din != 2'b11);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_re_sync <= '0;
    end else begin
      r_re_sync[0] <= bus.Re;
      for (int i = 1; i < SYNC_STAGES; i++) r_re_sync[i] <= r_re_sync[i-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr] <= bus.din;
  end

  // r_nempty_d delays the pop decision one edge, giving the two-edge accept-to-R latency
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_nempty_d <= 1'b0;
      r_alive    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_alive    <= 1'b1;
      r_err      <= bus.din_valid && (bus.din == 2'b11);
      r_nempty_d <= w_nempty;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_head_oh = 3'b000;
    case (r_mem[r_rptr])
      2'b00:   w_head_oh = 3'b001;
      2'b01:   w_head_oh = 3'b010;
      2'b10:   w_head_oh = 3'b100;
      default: w_head_oh = 3'b000;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_r_next     = r_R;
    w_pop        = 1'b0;
    w_tok_inc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_r_next = 3'b000;
        if (w_nempty && r_nempty_d && w_re_s) begin
          w_pop        = 1'b1;
          w_r_next     = w_head_oh;
          w_state_next = S_SEND;
        end
      end
      S_SEND: begin
        if (!w_re_s) begin
          w_r_next     = 3'b000;
          w_tok_inc    = 1'b1;
          w_state_next = S_NEUTRAL;
        end
      end
      S_NEUTRAL: begin
        w_r_next = 3'b000;
        if (w_re_s) w_state_next = S_IDLE;
      end
      default: begin
        w_r_next     = 3'b000;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= S_IDLE;
      r_R       <= 3'b000;
      r_tok_cnt <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_R     <= w_r_next;
      if (w_tok_inc) r_tok_cnt <= r_tok_cnt + 8'd1;
    end
  end

  assign bus.R         = r_R;
  assign bus.din_ready = w_din_ready;
  assign bus.err       = r_err;
  assign bus.tok_cnt   = r_tok_cnt;
  assign bus.busy      = w_nempty || (r_state != S_IDLE);

endmodule

// File: tb/tb_bin2qdi_e1of3_tx.sv
// Directed bench for bin2qdi_e1of3_tx: bench-side writer plus a four-phase receiver with 3-cycle Re delay.
module tb_bin2qdi_e1of3_tx;

  logic CLK;
  logic RESET;
  wire  VDD;
  wire  GND;
  assign VDD = 1'b1;
  assign GND = 1'b0;

  bin2qdi_e1of3_tx_if bus ();

  bin2qdi_e1of3_tx #(.DEPTH(4), .SYNC_STAGES(2)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .VDD   (VDD),
    .GND   (GND),
    .bus   (bus)
  );

  int         n_assert;
  int         n_fail;
  logic [7:0] exp_tok;
  logic [2:0] mon_prev;
  logic [1:0] t3_sym [5];
  logic [2:0] t3_exp [4];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [2:0] oh(input logic [1:0] sym);
    case (sym)
      2'b00:   return 3'b001;
      2'b01:   return 3'b010;
      2'b10:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic wait_r(input bit want_nonzero);
    int n = 0;
    while (((bus.R != 3'b000) != want_nonzero) && n < 64) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 64) begin
      tick();
      n++;
    end
  endtask

  task automatic write_sym(input logic [1:0] sym);
    bus.din       = sym;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
  endtask

  task automatic rx_token(input string tag, input logic [2:0] exp);
    wait_r(1'b1);
    chk({tag, "_code"}, 8'(bus.R), 8'(exp));
    repeat (3) tick();
    bus.Re = 1'b0;
    wait_r(1'b0);
    chk({tag, "_neutral"}, 8'(bus.R), 8'd0);
    exp_tok++;
    chk({tag, "_tok"}, bus.tok_cnt, exp_tok);
    repeat (3) tick();
    bus.Re = 1'b1;
  endtask

  task automatic do_reset();
    RESET         = 1'b0;
    bus.din_valid = 1'b0;
    repeat (2) tick();
    RESET = 1'b1;
    repeat (3) tick();
    exp_tok = 8'd0;
  endtask

  // R must stay one-hot/neutral and never step between two different codes
  always @(negedge CLK) begin
    if (RESET !== 1'b1) begin
      mon_prev = 3'b000;
    end else begin
      chk("r_onehot", 8'($countones(bus.R) <= 1), 8'd1);
      chk("r_code_step", 8'((mon_prev == 3'b000) || (bus.R == 3'b000) || (bus.R == mon_prev)), 8'd1);
      mon_prev = bus.R;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    exp_tok       = 8'd0;
    t3_sym        = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10};
    t3_exp        = '{3'b010, 3'b100, 3'b001, 3'b010};
    RESET         = 1'b0;
    bus.din       = 2'b00;
    bus.din_valid = 1'b0;
    bus.Re        = 1'b1;

    // reset values
    repeat (3) tick();
    chk("rst_R", 8'(bus.R), 8'd0);
    chk("rst_ready", 8'(bus.din_ready), 8'd0);
    chk("rst_err", 8'(bus.err), 8'd0);
    chk("rst_tok", bus.tok_cnt, 8'd0);
    chk("rst_busy", 8'(bus.busy), 8'd0);
    RESET = 1'b1;
    tick();
    chk("rel_ready", 8'(bus.din_ready), 8'd1);
    repeat (2) tick();

    // single symbol 01, latency of two edges
    write_sym(2'b01);
    chk("t1_lat_k", 8'(bus.R), 8'd0);
    tick();
    chk("t1_lat_k1", 8'(bus.R), 8'd0);
    tick();
    chk("t1_lat_k2", 8'(bus.R), 8'b010);
    chk("t1_busy", 8'(bus.busy), 8'd1);
    bus.Re = 1'b0;
    wait_r(1'b0);
    chk("t1_neutral", 8'(bus.R), 8'd0);
    chk("t1_tok", bus.tok_cnt, 8'd1);
    bus.Re = 1'b1;
    wait_idle();
    chk("t1_idle", 8'(bus.busy), 8'd0);

    // burst of four with the handshaking receiver
    do_reset();
    write_sym(2'b00);
    write_sym(2'b01);
    write_sym(2'b10);
    write_sym(2'b00);
    rx_token("t2_0", 3'b001);
    rx_token("t2_1", 3'b010);
    rx_token("t2_2", 3'b100);
    rx_token("t2_3", 3'b001);
    chk("t2_tok4", bus.tok_cnt, 8'd4);
    wait_idle();

    // invalid symbol 11
    bus.din       = 2'b11;
    bus.din_valid = 1'b1;
    chk("t4_ready", 8'(bus.din_ready), 8'd1);
    tick();
    bus.din_valid = 1'b0;
    chk("t4_err_hi", 8'(bus.err), 8'd1);
    chk("t4_busy", 8'(bus.busy), 8'd0);
    tick();
    chk("t4_err_lo", 8'(bus.err), 8'd0);
    repeat (6) tick();
    chk("t4_R", 8'(bus.R), 8'd0);
    chk("t4_tok", bus.tok_cnt, 8'd4);

    // receiver disabled: fill to full, fifth write refused
    bus.Re = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.din       = t3_sym[i];
      bus.din_valid = 1'b1;
      chk("t3_ready", 8'(bus.din_ready), (i < 4) ? 8'd1 : 8'd0);
      tick();
    end
    bus.din_valid = 1'b0;
    repeat (4) tick();
    chk("t3_R_held", 8'(bus.R), 8'd0);
    chk("t3_full", 8'(bus.din_ready), 8'd0);
    chk("t3_busy", 8'(bus.busy), 8'd1);
    bus.Re = 1'b1;
    for (int i = 0; i < 4; i++) rx_token("t3", t3_exp[i]);
    wait_idle();
    chk("t3_idle", 8'(bus.busy), 8'd0);
    chk("t3_no_fifth", 8'(bus.R), 8'd0);

    // reset while sending 100 with two entries queued
    do_reset();
    write_sym(2'b10);
    write_sym(2'b00);
    write_sym(2'b01);
    tick();
    chk("t5_send", 8'(bus.R), 8'b100);
    chk("t5_busy", 8'(bus.busy), 8'd1);
    RESET = 1'b0;
    #1;
    chk("t5_async_R", 8'(bus.R), 8'd0);
    chk("t5_rst_busy", 8'(bus.busy), 8'd0);
    chk("t5_rst_ready", 8'(bus.din_ready), 8'd0);
    repeat (2) tick();
    RESET = 1'b1;
    repeat (10) tick();
    chk("t5_no_stale", 8'(bus.R), 8'd0);
    chk("t5_busy_after", 8'(bus.busy), 8'd0);
    chk("t5_tok", bus.tok_cnt, 8'd0);
    exp_tok = 8'd0;

    // 257 tokens, counter wraps to 1
    for (int i = 0; i < 257; i++) begin
      write_sym(2'(i % 3));
      rx_token("t6", oh(2'(i % 3)));
    end
    chk("t6_wrap", bus.tok_cnt, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
